// File: rtl/core_scheduler_if.sv
// Bundle of control/status signals between the miniGPU core and its scheduler.
// The scheduler sits on the slave side; the core datapath (or a bench) drives the master side.
interface core_scheduler_if #(
   parameter int unsigned THREADS_PER_BLOCK = 4,
   parameter int unsigned PC_WIDTH          = 8
);
   logic                                  start;
   logic [THREADS_PER_BLOCK-1:0]          thread_enable;
   logic [2:0]                            fetcher_state;
   logic                                  decoded_mem_read_enable;
   logic                                  decoded_mem_write_enable;
   logic                                  decoded_ret;
   logic [2*THREADS_PER_BLOCK-1:0]        lsu_state;
   logic [PC_WIDTH*THREADS_PER_BLOCK-1:0] next_pc;
   logic [2:0]                            core_state;
   logic [PC_WIDTH-1:0]                   current_pc;
   logic                                  done;
   logic                                  diverged;

   modport master (
      output start, thread_enable, fetcher_state, decoded_mem_read_enable,
             decoded_mem_write_enable, decoded_ret, lsu_state, next_pc,
      input  core_state, current_pc, done, diverged
   );

   modport slave (
      input  start, thread_enable, fetcher_state, decoded_mem_read_enable,
             decoded_mem_write_enable, decoded_ret, lsu_state, next_pc,
      output core_state, current_pc, done, diverged
   );
endinterface

// File: rtl/core_scheduler.sv
// Per-core instruction sequencer: walks FETCH..UPDATE, owns the shared PC,
// reports block completion and flags lanes that disagree on the next PC.
module core_scheduler #(
   parameter int unsigned THREADS_PER_BLOCK = 4,
   parameter int unsigned PC_WIDTH          = 8
) (
   input logic               clk,
   input logic               reset,
   core_scheduler_if.slave   bus
);
   typedef enum logic [2:0] {
      StIdle    = 3'b000,
      StFetch   = 3'b001,
      StDecode  = 3'b010,
      StRequest = 3'b011,
      StWait    = 3'b100,
      StExecute = 3'b101,
      StUpdate  = 3'b110,
      StDone    = 3'b111
   } state_e;

   localparam logic [2:0] FetcherFetched = 3'b010;
   localparam logic [1:0] LsuRequesting  = 2'b01;
   localparam logic [1:0] LsuWaiting     = 2'b10;

   state_e              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                done_q, done_d;
   logic                div_q, div_d;

   logic                lane_busy;
   logic                lane_found;
   logic                lane_mismatch;
   logic [PC_WIDTH-1:0] sel_pc;

   // LSUs consume the decoded memory flags directly; the scheduler only watches lsu_state.
   logic unused_mem_op;
   assign unused_mem_op = bus.decoded_mem_read_enable ^ bus.decoded_mem_write_enable;

   always_comb begin
      lane_busy     = 1'b0;
      lane_found    = 1'b0;
      lane_mismatch = 1'b0;
      sel_pc        = bus.next_pc[PC_WIDTH-1:0];
      for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
         if (bus.thread_enable[i] && ((bus.lsu_state[2*i +: 2] == LsuRequesting) ||
                                      (bus.lsu_state[2*i +: 2] == LsuWaiting))) begin
            lane_busy = 1'b1;
         end
         if (bus.thread_enable[i] && !lane_found) begin
            sel_pc     = bus.next_pc[PC_WIDTH*i +: PC_WIDTH];
            lane_found = 1'b1;
         end
      end
      for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
         if (bus.thread_enable[i] && (bus.next_pc[PC_WIDTH*i +: PC_WIDTH] != sel_pc)) begin
            lane_mismatch = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      done_d  = done_q;
      div_d   = div_q;
      case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               state_d = StFetch;
               pc_d    = '0;
               done_d  = 1'b0;
               div_d   = 1'b0;
            end
         end
         StFetch: begin
            if (bus.fetcher_state == FetcherFetched) state_d = StDecode;
         end
         StDecode:  state_d = StRequest;
         StRequest: state_d = StWait;
         StWait: begin
            if (!lane_busy) state_d = StExecute;
         end
         StExecute: state_d = StUpdate;
         StUpdate: begin
            if (bus.decoded_ret) begin
               state_d = StDone;
               done_d  = 1'b1;
            end else begin
               state_d = StFetch;
               pc_d    = sel_pc;
               if (lane_mismatch) div_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         pc_q    <= '0;
         done_q  <= 1'b0;
         div_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         done_q  <= done_d;
         div_q   <= div_d;
      end
   end

   assign bus.core_state = state_q;
   assign bus.current_pc = pc_q;
   assign bus.done       = done_q;
   assign bus.diverged   = div_q;
endmodule

// File: tb/tb_core_scheduler.sv
// Randomized bench for core_scheduler: predicts every cycle's state, PC, done and
// divergence flag from per-instruction timing and lane PC rules.
module tb_core_scheduler;
   localparam int unsigned T = 4;
   localparam int unsigned W = 8;

   localparam logic [2:0] CsIdle    = 3'd0;
   localparam logic [2:0] CsFetch   = 3'd1;
   localparam logic [2:0] CsDecode  = 3'd2;
   localparam logic [2:0] CsRequest = 3'd3;
   localparam logic [2:0] CsWait    = 3'd4;
   localparam logic [2:0] CsExecute = 3'd5;
   localparam logic [2:0] CsUpdate  = 3'd6;
   localparam logic [2:0] CsDone    = 3'd7;

   localparam logic [1:0] LsuIdle = 2'd0;
   localparam logic [1:0] LsuReq  = 2'd1;
   localparam logic [1:0] LsuWait = 2'd2;
   localparam logic [1:0] LsuDone = 2'd3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   core_scheduler_if #(.THREADS_PER_BLOCK(T), .PC_WIDTH(W)) bus ();

   core_scheduler #(.THREADS_PER_BLOCK(T), .PC_WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [W-1:0] exp_pc;
   logic         exp_div;
   logic [T-1:0] en;
   logic [2:0]   prev_st;
   int           stall_a [T];
   logic [W-1:0] npc_a   [T];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic expect_cycle(input logic [2:0] st, input logic dn);
      check("core_state", 32'(bus.core_state), 32'(st));
      check("current_pc", 32'(bus.current_pc), 32'(exp_pc));
      check("diverged", 32'(bus.diverged), 32'(exp_div));
      check("done", 32'(bus.done), 32'(dn));
   endtask

   task automatic set_lanes(input logic [W-1:0] p0, input logic [W-1:0] p1,
                            input logic [W-1:0] p2, input logic [W-1:0] p3, input int s2);
      npc_a[0] = p0; npc_a[1] = p1; npc_a[2] = p2; npc_a[3] = p3;
      for (int i = 0; i < T; i++) stall_a[i] = 0;
      stall_a[2] = s2;
   endtask

   task automatic gen_lanes();
      logic [W-1:0] base;
      base = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'(exp_pc + 1'b1);
      for (int i = 0; i < T; i++) begin
         npc_a[i]   = ($urandom_range(0, 4) == 0) ? W'($urandom) : base;
         stall_a[i] = $urandom_range(0, 5);
      end
   endtask

   // One instruction: f_lat FETCH cycles, then fixed stages, WAIT stretched by the
   // slowest enabled lane's stall.
   task automatic run_instr(input bit ret, input int f_lat, input bit mem);
      int           wait_len;
      logic [W-1:0] enabled_pcs [$];
      for (int k = 0; k < f_lat; k++) begin
         bus.start         = 1'($urandom_range(0, 1));
         bus.fetcher_state = (k == f_lat - 1) ? 3'b010 : 3'b001;
         expect_cycle(CsFetch, 1'b0);
         tick();
      end
      bus.start                    = 1'($urandom_range(0, 1));
      bus.fetcher_state            = 3'b000;
      bus.decoded_mem_read_enable  = mem;
      bus.decoded_mem_write_enable = 1'b0;
      bus.decoded_ret              = ret;
      expect_cycle(CsDecode, 1'b0);
      tick();
      expect_cycle(CsRequest, 1'b0);
      tick();
      wait_len = 1;
      for (int i = 0; i < T; i++) begin
         if (en[i] && mem && (stall_a[i] + 1 > wait_len)) wait_len = stall_a[i] + 1;
      end
      for (int w = 0; w < wait_len; w++) begin
         for (int i = 0; i < T; i++) begin
            bus.lsu_state[2*i +: 2] = !mem ? LsuIdle :
                                      (w < stall_a[i]) ? ((w == 0) ? LsuReq : LsuWait) : LsuDone;
         end
         expect_cycle(CsWait, 1'b0);
         tick();
      end
      bus.lsu_state = '0;
      for (int i = 0; i < T; i++) bus.next_pc[W*i +: W] = npc_a[i];
      expect_cycle(CsExecute, 1'b0);
      tick();
      expect_cycle(CsUpdate, 1'b0);
      tick();
      if (!ret) begin
         for (int i = 0; i < T; i++) if (en[i]) enabled_pcs.push_back(npc_a[i]);
         exp_pc = (enabled_pcs.size() > 0) ? enabled_pcs[0] : npc_a[0];
         foreach (enabled_pcs[j]) if (enabled_pcs[j] != exp_pc) exp_div = 1'b1;
      end
   endtask

   task automatic start_block(input logic [T-1:0] mask);
      en                = mask;
      bus.thread_enable = mask;
      bus.start         = 1'b1;
      check("pre_start_state", 32'(bus.core_state), 32'(prev_st));
      tick();
      exp_pc  = '0;
      exp_div = 1'b0;
   endtask

   task automatic finish_block(input int hold);
      bus.start = 1'b0;
      for (int h = 0; h < hold; h++) begin
         expect_cycle(CsDone, 1'b1);
         tick();
      end
      prev_st = CsDone;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      tick();
      tick();
      reset   = 1'b0;
      exp_pc  = '0;
      exp_div = 1'b0;
      prev_st = CsIdle;
      expect_cycle(CsIdle, 1'b0);
   endtask

   initial begin
      reset                        = 1'b1;
      bus.start                    = 1'b0;
      bus.thread_enable            = '0;
      bus.fetcher_state            = 3'b000;
      bus.decoded_mem_read_enable  = 1'b0;
      bus.decoded_mem_write_enable = 1'b0;
      bus.decoded_ret              = 1'b0;
      bus.lsu_state                = '0;
      bus.next_pc                  = '0;
      en                           = '0;
      tick();
      apply_reset();
      for (int c = 0; c < 10; c++) begin
         expect_cycle(CsIdle, 1'b0);
         tick();
      end

      // Straight-line code, a lane-2 memory stall, then RET at 0x05.
      start_block(4'b1111);
      for (int j = 0; j < 4; j++) begin
         set_lanes(exp_pc + 1'b1, exp_pc + 1'b1, exp_pc + 1'b1, exp_pc + 1'b1, 0);
         run_instr(1'b0, 1, 1'b0);
      end
      set_lanes(8'h05, 8'h05, 8'h05, 8'h05, 5);
      run_instr(1'b0, 1, 1'b1);
      run_instr(1'b1, 1, 1'b0);
      finish_block(3);

      // Stall on a disabled lane must not hold WAIT.
      start_block(4'b1011);
      set_lanes(8'h01, 8'h01, 8'h77, 8'h01, 5);
      run_instr(1'b0, 2, 1'b1);
      run_instr(1'b1, 1, 1'b0);
      finish_block(2);

      // Divergence, sticky across convergent code, long fetch, PC wrap.
      start_block(4'b0110);
      set_lanes(8'h99, 8'h10, 8'h12, 8'h44, 0);
      run_instr(1'b0, 1, 1'b0);
      set_lanes(8'hFF, 8'hFF, 8'hFF, 8'hFF, 0);
      run_instr(1'b0, 8, 1'b0);
      set_lanes(8'h00, 8'h00, 8'h00, 8'h00, 0);
      run_instr(1'b0, 1, 1'b0);
      set_lanes(8'h33, 8'h33, 8'h33, 8'h33, 0);
      run_instr(1'b0, 1, 1'b0);
      run_instr(1'b1, 1, 1'b0);
      finish_block(2);
      apply_reset();

      // Reset while stalled in WAIT.
      start_block(4'b1111);
      bus.fetcher_state = 3'b010;
      expect_cycle(CsFetch, 1'b0);
      tick();
      bus.fetcher_state = 3'b000;
      expect_cycle(CsDecode, 1'b0);
      tick();
      expect_cycle(CsRequest, 1'b0);
      tick();
      bus.lsu_state = {LsuDone, LsuDone, LsuDone, LsuWait};
      expect_cycle(CsWait, 1'b0);
      tick();
      expect_cycle(CsWait, 1'b0);
      apply_reset();
      bus.lsu_state = '0;

      for (int b = 0; b < 30; b++) begin
         int n;
         start_block(T'($urandom_range(0, 15)));
         n = $urandom_range(1, 6);
         for (int j = 0; j < n; j++) begin
            gen_lanes();
            run_instr(j == n - 1, $urandom_range(1, 8), 1'($urandom_range(0, 1)));
         end
         finish_block($urandom_range(1, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
